// File: rtl/pong_pkg.sv
// Shared encodings and default timing for the pong paddle logic.
// Also holds a width helper that is used to size the counters.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SLOW = 2'd1,
    ST_FAST = 2'd2
  } paddle_state_e;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DOWN = 2'd2
  } paddle_dir_e;

  localparam int SLOW_TICKS_DEF  = 1250000;
  localparam int FAST_TICKS_DEF  = 625000;
  localparam int ACCEL_STEPS_DEF = 4;

  // Bits needed to hold the values 0..n-1. The result is never less than 1.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/paddle_motion_ctrl_if.sv
// Handshake between the motion FSM (master) and its tick generator (slave).
interface paddle_motion_ctrl_if;
  logic clear;
  logic enable;
  logic fast_sel;
  logic tc;

  modport master (output clear, output enable, output fast_sel, input tc);
  modport slave  (input clear, input enable, input fast_sel, output tc);
endinterface

// File: rtl/paddle_tick_gen.sv
// Step-rate tick counter. The period is selected at run time (slow or fast).
// tc pulses on the last tick of the period, and the count wraps to 0 on that cycle.
module paddle_tick_gen
  import pong_pkg::*;
#(
  parameter int c_SLOW_TICKS = SLOW_TICKS_DEF,
  parameter int c_FAST_TICKS = FAST_TICKS_DEF
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst,
  paddle_motion_ctrl_if.slave  tick_if
);

  localparam int c_CNT_W = cnt_width(c_SLOW_TICKS);
  localparam logic [c_CNT_W-1:0] c_SLOW_LAST = c_CNT_W'(c_SLOW_TICKS - 1);
  localparam logic [c_CNT_W-1:0] c_FAST_LAST = c_CNT_W'(c_FAST_TICKS - 1);

  logic [c_CNT_W-1:0] cnt_q;
  logic [c_CNT_W-1:0] cnt_d;
  logic [c_CNT_W-1:0] last_cnt;

  assign last_cnt   = tick_if.fast_sel ? c_FAST_LAST : c_SLOW_LAST;
  assign tick_if.tc = tick_if.enable && (cnt_q == last_cnt);

  always_comb begin
    // NOTE: the default comes first, so every path assigns cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (tick_if.clear) begin
      cnt_d = '0;
    end else if (tick_if.enable) begin
      cnt_d = tick_if.tc ? '0 : cnt_q + c_CNT_W'(1);
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/paddle_motion_ctrl.sv
// Paddle position controller. It has manual or ball-tracking requests.
// Motion runs in an IDLE/SLOW/FAST FSM that accelerates, and the paddle pixel is drawn from a register.
module paddle_motion_ctrl
  import pong_pkg::*;
#(
  parameter int c_PLAYER_PADDLE_X = 0,
  parameter int c_PADDLE_HEIGHT   = 6,
  parameter int c_GAME_HEIGHT     = 30,
  parameter int c_COORD_W         = 6,
  parameter int c_SLOW_TICKS      = SLOW_TICKS_DEF,
  parameter int c_FAST_TICKS      = FAST_TICKS_DEF,
  parameter int c_ACCEL_STEPS     = ACCEL_STEPS_DEF,
  parameter int c_RESET_Y         = (c_GAME_HEIGHT - c_PADDLE_HEIGHT) / 2
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst,
  input  logic [c_COORD_W-1:0] i_Col_Count_Div,
  input  logic [c_COORD_W-1:0] i_Row_Count_Div,
  input  logic                 i_Paddle_Up,
  input  logic                 i_Paddle_Dn,
  input  logic                 i_Auto_En,
  input  logic [c_COORD_W-1:0] i_Ball_Y,
  output logic                 o_Draw_Paddle,
  output logic [c_COORD_W-1:0] o_Paddle_Y,
  output logic                 o_At_Top,
  output logic                 o_At_Bottom,
  output logic                 o_Moving
);

  localparam int c_STEP_W = cnt_width(c_ACCEL_STEPS);
  localparam logic [c_COORD_W-1:0] c_Y_MAX    = c_COORD_W'(c_GAME_HEIGHT - c_PADDLE_HEIGHT);
  localparam logic [c_COORD_W-1:0] c_Y_RST    = c_COORD_W'(c_RESET_Y);
  localparam logic [c_COORD_W-1:0] c_PADDLE_X = c_COORD_W'(c_PLAYER_PADDLE_X);
  localparam logic [c_COORD_W-1:0] c_ONE      = c_COORD_W'(1);
  localparam logic [c_COORD_W:0]   c_H_M1     = (c_COORD_W + 1)'(c_PADDLE_HEIGHT - 1);
  localparam logic [c_STEP_W-1:0]  c_LAST_SLOW_STEP = c_STEP_W'(c_ACCEL_STEPS - 1);

  paddle_state_e        state_q, state_d;
  paddle_dir_e          dir_q, dir_d;
  paddle_dir_e          req;
  logic [c_COORD_W-1:0] y_q, y_d;
  logic [c_STEP_W-1:0]  step_q, step_d;
  logic                 draw_q, draw_d;
  logic                 can_move;
  logic                 tick_clear, tick_enable;

  // Extra top bit so that the paddle's bottom row never wraps.
  logic [c_COORD_W:0] y_ext, y_bot, row_ext, ball_ext;

  paddle_motion_ctrl_if tick_if ();

  assign tick_if.clear    = tick_clear;
  assign tick_if.enable   = tick_enable;
  assign tick_if.fast_sel = (state_q == ST_FAST);

  paddle_tick_gen #(
    .c_SLOW_TICKS (c_SLOW_TICKS),
    .c_FAST_TICKS (c_FAST_TICKS)
  ) u_tick_gen (
    .i_Clk   (i_Clk),
    .i_Rst   (i_Rst),
    .tick_if (tick_if)
  );

  assign y_ext    = {1'b0, y_q};
  assign y_bot    = y_ext + c_H_M1;
  assign row_ext  = {1'b0, i_Row_Count_Div};
  assign ball_ext = {1'b0, i_Ball_Y};

  always_comb begin
    req = DIR_NONE;
    if (i_Auto_En) begin
      if (ball_ext < y_ext)      req = DIR_UP;
      else if (ball_ext > y_bot) req = DIR_DOWN;
    end else begin
      if (i_Paddle_Up && !i_Paddle_Dn)      req = DIR_UP;
      else if (i_Paddle_Dn && !i_Paddle_Up) req = DIR_DOWN;
    end
  end

  assign can_move = (dir_q == DIR_UP)   ? (y_q != '0) :
                    (dir_q == DIR_DOWN) ? (y_q != c_Y_MAX) : 1'b0;

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    y_d         = y_q;
    step_d      = step_q;
    tick_clear  = 1'b0;
    tick_enable = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        tick_clear = 1'b1;
        step_d     = '0;
        if (req != DIR_NONE) begin
          state_d = ST_SLOW;
          dir_d   = req;
        end
      end
      ST_SLOW, ST_FAST: begin
        if (req == DIR_NONE) begin
          state_d    = ST_IDLE;
          step_d     = '0;
          tick_clear = 1'b1;
        end else if (req != dir_q) begin
          // A reversal starts over in slow mode, and no step is taken on this cycle.
          state_d    = ST_SLOW;
          dir_d      = req;
          step_d     = '0;
          tick_clear = 1'b1;
        end else begin
          tick_enable = 1'b1;
          if (tick_if.tc && can_move) begin
            y_d = (dir_q == DIR_UP) ? y_q - c_ONE : y_q + c_ONE;
            if (state_q == ST_SLOW) begin
              if (step_q == c_LAST_SLOW_STEP) begin
                state_d = ST_FAST;
                step_d  = '0;
              end else begin
                step_d = step_q + c_STEP_W'(1);
              end
            end
          end
        end
      end
      default: begin
        state_d    = ST_IDLE;
        tick_clear = 1'b1;
      end
    endcase
  end

  assign draw_d = (i_Col_Count_Div == c_PADDLE_X) && (row_ext >= y_ext) && (row_ext <= y_bot);

  always_ff @(posedge i_Clk) begin
    // NOTE: state registers use non-blocking assignments only, so every flop samples values from before the edge.
    if (i_Rst) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_UP;
      y_q     <= c_Y_RST;
      step_q  <= '0;
      draw_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      y_q     <= y_d;
      step_q  <= step_d;
      draw_q  <= draw_d;
    end
  end

  assign o_Draw_Paddle = draw_q;
  assign o_Paddle_Y    = y_q;
  assign o_At_Top      = (y_q == '0);
  assign o_At_Bottom   = (y_q == c_Y_MAX);
  assign o_Moving      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_paddle_motion_ctrl.sv
// Directed bench for paddle_motion_ctrl with short timing (slow 4, fast 2, accel 3).
// Inputs change 1 time unit after a rising edge, and outputs are sampled at the same point.
module tb_paddle_motion_ctrl;

  logic       i_Clk = 1'b0;
  logic       i_Rst;
  logic [5:0] i_Col_Count_Div;
  logic [5:0] i_Row_Count_Div;
  logic       i_Paddle_Up;
  logic       i_Paddle_Dn;
  logic       i_Auto_En;
  logic [5:0] i_Ball_Y;
  logic       o_Draw_Paddle;
  logic [5:0] o_Paddle_Y;
  logic       o_At_Top;
  logic       o_At_Bottom;
  logic       o_Moving;

  int total = 0;
  int bad   = 0;

  paddle_motion_ctrl #(
    .c_PLAYER_PADDLE_X (0),
    .c_PADDLE_HEIGHT   (6),
    .c_GAME_HEIGHT     (30),
    .c_COORD_W         (6),
    .c_SLOW_TICKS      (4),
    .c_FAST_TICKS      (2),
    .c_ACCEL_STEPS     (3),
    .c_RESET_Y         (12)
  ) dut (
    .i_Clk           (i_Clk),
    .i_Rst           (i_Rst),
    .i_Col_Count_Div (i_Col_Count_Div),
    .i_Row_Count_Div (i_Row_Count_Div),
    .i_Paddle_Up     (i_Paddle_Up),
    .i_Paddle_Dn     (i_Paddle_Dn),
    .i_Auto_En       (i_Auto_En),
    .i_Ball_Y        (i_Ball_Y),
    .o_Draw_Paddle   (o_Draw_Paddle),
    .o_Paddle_Y      (o_Paddle_Y),
    .o_At_Top        (o_At_Top),
    .o_At_Bottom     (o_At_Bottom),
    .o_Moving        (o_Moving)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycle(input int n);
    repeat (n) @(posedge i_Clk);
    #1;
  endtask

  initial begin
    i_Rst           = 1'b1;
    i_Col_Count_Div = 6'd0;
    i_Row_Count_Div = 6'd12;
    i_Paddle_Up     = 1'b0;
    i_Paddle_Dn     = 1'b0;
    i_Auto_En       = 1'b0;
    i_Ball_Y        = 6'd0;

    // Reset state. The pixel at col 0, row 12 would be on the paddle if reset did not force draw low.
    cycle(3);
    check("rst_y", o_Paddle_Y, 12);
    check("rst_draw", o_Draw_Paddle, 0);
    check("rst_moving", o_Moving, 0);
    check("rst_top", o_At_Top, 0);
    check("rst_bottom", o_At_Bottom, 0);

    // Hold Up from edge 0. Y is 11 at edge 4, 10 at 8, 9 at 12 (FAST), 8 at 14, 7 at 16.
    i_Rst       = 1'b0;
    i_Paddle_Up = 1'b1;
    cycle(4);
    check("up_e3_y", o_Paddle_Y, 12);
    check("up_e3_moving", o_Moving, 1);
    cycle(1);  check("up_e4_y", o_Paddle_Y, 11);
    cycle(4);  check("up_e8_y", o_Paddle_Y, 10);
    cycle(4);  check("up_e12_y", o_Paddle_Y, 9);
    cycle(2);  check("up_e14_y", o_Paddle_Y, 8);
    cycle(2);  check("up_e16_y", o_Paddle_Y, 7);
    i_Paddle_Up = 1'b0;
    cycle(1);
    check("rel_moving", o_Moving, 0);
    check("rel_y", o_Paddle_Y, 7);
    cycle(3);  check("rel_hold_y", o_Paddle_Y, 7);

    // Up and Dn pressed together give no request.
    i_Paddle_Up = 1'b1;
    i_Paddle_Dn = 1'b1;
    cycle(20);
    check("both_y", o_Paddle_Y, 7);
    check("both_moving", o_Moving, 0);

    // Go Up into FAST, then reverse while a FAST step is due on the next edge.
    i_Paddle_Dn = 1'b0;
    cycle(15); check("rev_fast_y", o_Paddle_Y, 3);
    cycle(1);  check("rev_pre_y", o_Paddle_Y, 3);
    i_Paddle_Up = 1'b0;
    i_Paddle_Dn = 1'b1;
    cycle(1);
    check("rev_nostep_y", o_Paddle_Y, 3);
    check("rev_moving", o_Moving, 1);
    cycle(3);  check("rev_e19_y", o_Paddle_Y, 3);
    cycle(1);  check("rev_e20_y", o_Paddle_Y, 4);

    // Reset in the middle of a move. Dn stays held through it, and the move restarts from Y=12.
    cycle(1);
    i_Rst = 1'b1;
    cycle(1);
    check("midrst_y", o_Paddle_Y, 12);
    check("midrst_moving", o_Moving, 0);
    i_Rst = 1'b0;
    cycle(4);  check("down_e3_y", o_Paddle_Y, 12);
    cycle(1);  check("down_e4_y", o_Paddle_Y, 13);
    cycle(26);
    check("bot_e30_y", o_Paddle_Y, 24);
    check("bot_flag", o_At_Bottom, 1);
    cycle(20);
    check("bot_hold_y", o_Paddle_Y, 24);
    check("bot_hold_flag", o_At_Bottom, 1);
    check("bot_hold_moving", o_Moving, 1);
    i_Paddle_Dn = 1'b0;
    cycle(1);  check("bot_rel_moving", o_Moving, 0);

    // Auto mode from Y=12. Ball at row 2 is reached at edge 26, and the Dn button is ignored.
    i_Rst = 1'b1;
    cycle(1);
    i_Rst       = 1'b0;
    i_Auto_En   = 1'b1;
    i_Ball_Y    = 6'd2;
    i_Paddle_Dn = 1'b1;
    cycle(26); check("auto_e25_y", o_Paddle_Y, 3);
    cycle(1);  check("auto_e26_y", o_Paddle_Y, 2);
    cycle(1);
    check("auto_stop_moving", o_Moving, 0);
    check("auto_stop_y", o_Paddle_Y, 2);
    // Ball at row 20: the paddle stops at Y=15, where its bottom row 20 covers the ball. That takes 13 steps, ending at edge 32.
    i_Ball_Y = 6'd20;
    cycle(33); check("auto_dn_y", o_Paddle_Y, 15);
    cycle(1);  check("auto_dn_moving", o_Moving, 0);
    cycle(3);  check("auto_dn_hold_y", o_Paddle_Y, 15);
    // Ball at row 0: the paddle reaches the top at edge 36.
    i_Ball_Y = 6'd0;
    cycle(37);
    check("auto_top_y", o_Paddle_Y, 0);
    check("auto_top_flag", o_At_Top, 1);
    cycle(1);  check("auto_top_moving", o_Moving, 0);
    i_Auto_En   = 1'b0;
    i_Paddle_Dn = 1'b0;

    // Draw decode with Y=12. Each result appears one cycle after the row is applied.
    i_Rst = 1'b1;
    cycle(1);
    i_Rst = 1'b0;
    i_Col_Count_Div = 6'd0;
    i_Row_Count_Div = 6'd11; cycle(1); check("draw_r11", o_Draw_Paddle, 0);
    i_Row_Count_Div = 6'd12; cycle(1); check("draw_r12", o_Draw_Paddle, 1);
    i_Row_Count_Div = 6'd17; cycle(1); check("draw_r17", o_Draw_Paddle, 1);
    i_Row_Count_Div = 6'd18; cycle(1); check("draw_r18", o_Draw_Paddle, 0);
    i_Row_Count_Div = 6'd63; cycle(1); check("draw_r63", o_Draw_Paddle, 0);
    i_Col_Count_Div = 6'd1;
    i_Row_Count_Div = 6'd12; cycle(1); check("draw_col1", o_Draw_Paddle, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
